// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback (port A) has strict priority; port B
// results are buffered in an in-order FIFO and drained into idle write slots.
module rf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_we,
    input  logic [4:0]               a_addr,
    input  logic [31:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_addr,
    input  logic [31:0]              b_data,
    output logic                     rf_reg_write,
    output logic [4:0]               rf_write_addr,
    output logic [31:0]              rf_write_data,
    input  logic [4:0]               chk_addr_1,
    input  logic [4:0]               chk_addr_2,
    output logic                     pend_hit,
    output logic                     bubble_req,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT) + 1;

    logic             active;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    wait_cnt;
    logic [DEPTH-1:0] ent_vld;
    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic a_wr;
    logic fifo_ne;
    logic pop;
    logic push;
    logic b_hs;
    logic blocked;

    // active holds every output low while reset is asserted and for the release cycle
    assign a_wr       = active & a_we & (a_addr != 5'd0);
    assign fifo_ne    = (count != '0);
    assign pop        = active & ~a_wr & fifo_ne;
    assign b_ready    = active & ((count < CW'(DEPTH)) | pop);
    assign b_hs       = b_valid & b_ready;
    assign push       = b_hs & (b_addr != 5'd0);
    assign blocked    = a_wr & fifo_ne;
    assign fifo_count = count;

    always_comb begin
        rf_reg_write  = 1'b0;
        rf_write_addr = 5'd0;
        rf_write_data = 32'd0;
        if (a_wr) begin
            rf_reg_write  = 1'b1;
            rf_write_addr = a_addr;
            rf_write_data = a_data;
        end else if (pop) begin
            rf_reg_write  = 1'b1;
            rf_write_addr = addr_mem[rd_ptr];
            rf_write_data = data_mem[rd_ptr];
        end
    end

    // Hazard check covers queued entries plus the entry being accepted this cycle
    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] &&
                (((chk_addr_1 != 5'd0) && (addr_mem[i] == chk_addr_1)) ||
                 ((chk_addr_2 != 5'd0) && (addr_mem[i] == chk_addr_2))))
                pend_hit = 1'b1;
        end
        if (b_hs &&
            (((chk_addr_1 != 5'd0) && (b_addr == chk_addr_1)) ||
             ((chk_addr_2 != 5'd0) && (b_addr == chk_addr_2))))
            pend_hit = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wait_cnt   <= '0;
            ent_vld    <= '0;
            bubble_req <= 1'b0;
        end else begin
            active <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            // When full, push and pop share a slot; the push must win
            if (pop)
                ent_vld[rd_ptr] <= 1'b0;
            if (push)
                ent_vld[wr_ptr] <= 1'b1;

            bubble_req <= 1'b0;
            if (!blocked) begin
                wait_cnt <= '0;
            end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                bubble_req <= 1'b1;
                wait_cnt   <= '0;
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    // Payload storage carries no reset; ent_vld qualifies every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= b_addr;
            data_mem[wr_ptr] <= b_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected register-file writes are queued
// by the stimulus thread and checked by a negedge monitor.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_reg_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  chk_addr_1;
    logic [4:0]  chk_addr_2;
    logic        pend_hit;
    logic        bubble_req;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q [$];

    rf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_reg_write(rf_reg_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .pend_hit(pend_hit), .bubble_req(bubble_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_we    = we;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
    endtask

    // Monitor: every presented write must match the head of the expectation queue
    always @(negedge clk) begin
        logic [36:0] e;
        if (rf_reg_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%0d:0x%0h expected=none",
                         rf_write_addr, rf_write_data);
            end else begin
                e = exp_q.pop_front();
                if (rf_write_addr !== e[36:32] || rf_write_data !== e[31:0]) begin
                    failures++;
                    $display("FAIL rf_write actual=%0d:0x%0h expected=%0d:0x%0h",
                             rf_write_addr, rf_write_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        chk_addr_1 = 5'd0;
        chk_addr_2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset state
        repeat (3) tick;
        #3;
        chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_pend_hit", 32'(pend_hit), 32'd0);
        chk("rst_bubble_req", 32'(bubble_req), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        #3;
        chk("post_rst_b_ready", 32'(b_ready), 32'd1);

        // Port-A write passes straight through
        tick;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        exp_wr(5'd5, 32'hDEADBEEF);
        #3;
        chk("a_only_fifo_count", 32'(fifo_count), 32'd0);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // B-only write: buffered one cycle
        tick;
        chk_addr_1 = 5'd7;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        #3;
        chk("b_only_ready", 32'(b_ready), 32'd1);
        chk("b_only_pend_hs", 32'(pend_hit), 32'd1);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_wr(5'd7, 32'h1234);
        #3;
        chk("b_only_count_c1", 32'(fifo_count), 32'd1);
        chk("b_only_pend_c1", 32'(pend_hit), 32'd1);
        tick;
        #3;
        chk("b_only_count_c2", 32'(fifo_count), 32'd0);
        chk("b_only_pend_c2", 32'(pend_hit), 32'd0);
        chk_addr_1 = 5'd0;

        // Fill FIFO while port A holds the write port
        for (int i = 0; i < 5; i++) begin
            tick;
            drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(i + 1), 32'h101 + 32'(i));
            exp_wr(5'(10 + i), 32'hA0 + 32'(i));
            #3;
            chk("fill_count", 32'(fifo_count), 32'(i));
            chk("fill_b_ready", 32'(b_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
        exp_wr(5'd1, 32'h101);
        #3;
        chk("full_pop_b_ready", 32'(b_ready), 32'd1);
        chk("full_pop_count", 32'(fifo_count), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            tick;
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            chk_addr_2 = (i == 3) ? 5'd5 : 5'd0;
            exp_wr(5'(i), 32'h100 + 32'(i));
            #3;
            chk("drain_count", 32'(fifo_count), 32'(6 - i));
            if (i == 3)
                chk("drain_pend_hit", 32'(pend_hit), 32'd1);
        end
        tick;
        chk_addr_2 = 5'd0;
        #3;
        chk("drained_count", 32'(fifo_count), 32'd0);

        // Starvation guard
        tick;
        drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd12, 32'hC0C0);
        exp_wr(5'd6, 32'h600);
        for (int i = 1; i <= 9; i++) begin
            tick;
            drive(1'b1, 5'd6, 32'h600 + 32'(i), 1'b0, 5'd0, 32'd0);
            exp_wr(5'd6, 32'h600 + 32'(i));
            #3;
            chk("starve_bubble", 32'(bubble_req), (i == 9) ? 32'd1 : 32'd0);
        end
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_wr(5'd12, 32'hC0C0);
        #3;
        chk("starve_release_bubble", 32'(bubble_req), 32'd0);
        tick;
        #3;
        chk("starve_after_bubble", 32'(bubble_req), 32'd0);
        chk("starve_after_count", 32'(fifo_count), 32'd0);

        // x0 filtering
        tick;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h9999);
        exp_wr(5'd3, 32'h33);
        tick;
        drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
        chk_addr_2 = 5'd9;
        exp_wr(5'd9, 32'h9999);
        #3;
        chk("x0_a_count", 32'(fifo_count), 32'd1);
        chk("x0_a_pend_hit", 32'(pend_hit), 32'd1);
        tick;
        chk_addr_2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        #3;
        chk("x0_b_ready", 32'(b_ready), 32'd1);
        chk("x0_b_count", 32'(fifo_count), 32'd0);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("x0_b_count_after", 32'(fifo_count), 32'd0);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            tick;
            drive(1'b1, 5'(21 + i), 32'h2100 + 32'(i), 1'b1, 5'(13 + i), 32'hB00 + 32'(i));
            exp_wr(5'(21 + i), 32'h2100 + 32'(i));
        end
        tick;
        drive(1'b1, 5'd24, 32'h2400, 1'b0, 5'd0, 32'd0);
        chk_addr_1 = 5'd14;
        exp_wr(5'd24, 32'h2400);
        #3;
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_pend_hit", 32'(pend_hit), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("async_rst_pend_hit", 32'(pend_hit), 32'd0);
        chk("async_rst_b_ready", 32'(b_ready), 32'd0);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_addr_1 = 5'd0;
        tick;
        reset = 1'b0;
        repeat (4) tick;
        #3;
        chk("post_rel_count", 32'(fifo_count), 32'd0);
        chk("post_rel_b_ready", 32'(b_ready), 32'd1);
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the pipeline writeback stage (port A, highest priority, never back-pressured);
  - a long-latency unit such as a multiply/divide or memory-miss unit (port B, valid/ready, buffered).
- Sits between writeback and the register file, driving its write address, write data and write-enable inputs.
- Also reports read-after-write hazards against buffered-but-unwritten B results so decode can stall.

Parameters:
- DEPTH, 4, entries in the port-B pending FIFO (power of two, ≥2).
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO may be blocked by port A before a bubble is requested.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_we  in  1  writeback write request.
- a_addr  in  5  writeback destination register.
- a_data  in  32  writeback data.
- b_valid  in  1  port-B result valid.
- b_ready  out  1  port-B result accepted this cycle.
- b_addr  in  5  port-B destination register.
- b_data  in  32  port-B data.
- rf_reg_write  out  1  register file write enable.
- rf_write_addr  out  5  register file write address.
- rf_write_data  out  32  register file write data.
- chk_addr_1  in  5  decode source register 1.
- chk_addr_2  in  5  decode source register 2.
- pend_hit  out  1  a checked register has a buffered B write outstanding.
- bubble_req  out  1  request to pipeline to insert one writeback bubble.
- fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers, count and wait counter cleared.
  - All outputs 0; b_ready goes 1 in the first cycle after reset release.
- Port-A requests with a_addr==0 are treated as a_we=0.
- Port-B requests with b_addr==0 are accepted (b_ready handshake completes) but never enqueued.
- Write-port selection, combinational, same cycle:
  - a_we=1 → rf_* driven from port A; the FIFO head stays.
  - else FIFO non-empty → rf_* driven from the FIFO head; the head pops at the clock edge.
  - else rf_reg_write=0; rf_write_addr/rf_write_data are 0.
- Port-B acceptance:
  - b_ready = (count<DEPTH) OR (count==DEPTH AND head pops this cycle).
  - Handshake is b_valid & b_ready; an accepted entry pushes at the clock edge.
  - Port B never bypasses the FIFO: minimum B→register file latency is 1 cycle.
- Ordering:
  - FIFO entries are written strictly in order.
  - Same-cycle push and pop keep count unchanged.
  - Pointers wrap modulo DEPTH.
- Same-address collisions:
  - A FIFO entry and a later port-A write to the same register are written in arbitration order.
  - Software/pipeline correctness relies on pend_hit stalls, so the arbiter does no address merging.
- pend_hit:
  - Combinational.
  - 1 if any valid FIFO entry's address equals a nonzero chk_addr_1 or chk_addr_2.
  - Also 1 if a port-B handshake this cycle targets either checked register.
- Starvation guard:
  - wait_cnt increments each cycle with a_we=1 and count>0; clears when a FIFO pop occurs or the FIFO is empty.
  - bubble_req is registered: asserted for exactly one cycle when wait_cnt reaches MAX_WAIT-1 while still blocked, then wait_cnt clears.
  - The arbiter still obeys port-A priority if the pipeline ignores bubble_req.
- Reset asserted mid-operation discards all buffered entries; they are not written.

Test Plan:
- Reset, then a_we=1, a_addr=5, a_data=0xDEADBEEF → same cycle: rf_reg_write=1, rf_write_addr=5, rf_write_data=0xDEADBEEF; fifo_count stays 0.
- B-only write: b_valid=1, b_addr=7, b_data=0x1234 for 1 cycle, port A idle:
  - cycle 0: b_ready=1, pend_hit=1 for chk_addr_1=7;
  - cycle 1: rf_write_addr=7, rf_write_data=0x1234;
  - cycle 2: fifo_count=0, pend_hit=0.
- Fill FIFO: a_we=1 every cycle, b_valid=1 with addresses 1..5:
  - first 4 accepted, b_ready=0 on the 5th;
  - after a_we drops, rf writes 1,2,3,4 in order on consecutive cycles; the 5th is accepted in the cycle the head pops.
- Starvation: one FIFO entry plus a_we=1 continuously → bubble_req=1 exactly one cycle after 8 blocked cycles; drop a_we one cycle → entry written, bubble_req stays 0.
- x0 filtering:
  - a_we=1, a_addr=0 with FIFO holding entry 9 → rf writes 9 that cycle;
  - b_addr=0 handshake → fifo_count unchanged.
- Reset asserted asynchronously mid-cycle with 3 entries queued → fifo_count=0, rf_reg_write=0 and pend_hit=0 immediately; no queued entry is written after release.
